// File: rtl/vc_arb_defs.sv
// Shared definitions for the two-VC weighted round-robin arbiter:
// FSM state encoding and counter widths.
package vc_arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int CNT_W = 8;
  localparam int GNT_W = 16;

endpackage

// File: rtl/vc_grant_counter.sv
// Saturating grant total; holds at all-ones once reached.
import vc_arb_defs::*;

module vc_grant_counter (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [GNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + GNT_W'(1);
    end
  end

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Two-VC weighted round-robin arbiter: reads one of two FIFOs per cycle and
// forwards the returned word one cycle later tagged with its source VC.
//
// state | meaning
// IDLE  | no grant last cycle
// GNT0  | last grant went to VC0
// GNT1  | last grant went to VC1
import vc_arb_defs::*;

module vc_wrr_arbiter #(
  parameter int BW = 6,
  parameter int W0 = 4,
  parameter int W1 = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          pause,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  output logic          vc_id,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
);

  localparam logic [CNT_W-1:0] W0_C = CNT_W'(W0);
  localparam logic [CNT_W-1:0] W1_C = CNT_W'(W1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             e0, e1;
  logic             rd0, rd1;

  assign e0 = !VC0_empty && !pause && !reset;
  assign e1 = !VC1_empty && !pause && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    rd0       = 1'b0;
    rd1       = 1'b0;
    state_nxt = IDLE;
    cnt_nxt   = '0;
    unique case (state)
      GNT0: begin
        if (e0 && ((cnt < W0_C) || !e1)) begin
          rd0       = 1'b1;
          state_nxt = GNT0;
          // saturate at the weight so a lone VC keeps streaming
          cnt_nxt   = (cnt < W0_C) ? cnt + CNT_W'(1) : cnt;
        end else if (e1) begin
          rd1       = 1'b1;
          state_nxt = GNT1;
          cnt_nxt   = CNT_W'(1);
        end
      end
      GNT1: begin
        if (e1 && ((cnt < W1_C) || !e0)) begin
          rd1       = 1'b1;
          state_nxt = GNT1;
          cnt_nxt   = (cnt < W1_C) ? cnt + CNT_W'(1) : cnt;
        end else if (e0) begin
          rd0       = 1'b1;
          state_nxt = GNT0;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        if (e0) begin
          rd0       = 1'b1;
          state_nxt = GNT0;
          cnt_nxt   = CNT_W'(1);
        end else if (e1) begin
          rd1       = 1'b1;
          state_nxt = GNT1;
          cnt_nxt   = CNT_W'(1);
        end
      end
    endcase
  end

  assign VC0_rd = rd0;
  assign VC1_rd = rd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      vc_id     <= 1'b0;
    end else begin
      valid_out <= rd0 | rd1;
      if (rd0 | rd1) begin
        vc_id <= rd1;
      end
    end
  end

  // FIFO read data arrives the cycle after rd, aligned with vc_id
  assign data_out = vc_id ? VC1_data_out : VC0_data_out;

  vc_grant_counter u_gnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (rd0),
    .count (gnt_cnt0)
  );

  vc_grant_counter u_gnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (rd1),
    .count (gnt_cnt1)
  );

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed bench for vc_wrr_arbiter (BW=6, W0=4, W1=1).
module tb_vc_wrr_arbiter;

  logic        clk;
  logic        reset;
  logic        VC0_empty, VC1_empty;
  logic [5:0]  VC0_data_out, VC1_data_out;
  logic        pause;
  logic        VC0_rd, VC1_rd;
  logic [5:0]  data_out;
  logic        valid_out;
  logic        vc_id;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  vc_wrr_arbiter #(.BW(6), .W0(4), .W1(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .VC0_empty    (VC0_empty),
    .VC1_empty    (VC1_empty),
    .VC0_data_out (VC0_data_out),
    .VC1_data_out (VC1_data_out),
    .pause        (pause),
    .VC0_rd       (VC0_rd),
    .VC1_rd       (VC1_rd),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .vc_id        (vc_id),
    .gnt_cnt0     (gnt_cnt0),
    .gnt_cnt1     (gnt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pause = 1'b0;
    VC0_empty = 1'b0; VC1_empty = 1'b0;
    VC0_data_out = 6'h00; VC1_data_out = 6'h00;
    #1;
    n_cmp++;
    if ({VC0_rd, VC1_rd} !== 2'b00) begin
      n_err++; $display("FAIL reset_rd: got %b want 00", {VC0_rd, VC1_rd});
    end
    step(); step();
    n_cmp++;
    if ({valid_out, vc_id} !== 2'b00) begin
      n_err++; $display("FAIL reset_valid_vcid: got %b want 00", {valid_out, vc_id});
    end
    n_cmp++;
    if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
      n_err++; $display("FAIL reset_gnt: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1);
    end
    reset = 1'b0;
  endtask

  task automatic test_weighted_pattern();
    logic [9:0] pat;
    logic       prev_rd1;
    pat = 10'b1000010000;  // bit i = expected VC1_rd on grant i
    do_reset();
    VC0_empty = 1'b0; VC1_empty = 1'b0; pause = 1'b0;
    prev_rd1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (VC0_rd !== !pat[i] || VC1_rd !== pat[i]) begin
        n_err++; $display("FAIL wrr_pattern[%0d]: got rd0=%b rd1=%b want rd0=%b rd1=%b",
                          i, VC0_rd, VC1_rd, !pat[i], pat[i]);
      end
      if (i > 0) begin
        n_cmp++;
        if (valid_out !== 1'b1 || vc_id !== prev_rd1) begin
          n_err++; $display("FAIL wrr_valid[%0d]: got valid=%b vc_id=%b want 1/%b",
                            i, valid_out, vc_id, prev_rd1);
        end
      end
      prev_rd1 = pat[i];
      step();
    end
    n_cmp++;
    if (gnt_cnt0 !== 16'd8 || gnt_cnt1 !== 16'd2) begin
      n_err++; $display("FAIL wrr_gnt: got %0d/%0d want 8/2", gnt_cnt0, gnt_cnt1);
    end
  endtask

  task automatic test_vc1_only();
    do_reset();
    VC0_empty = 1'b1; VC1_empty = 1'b0; pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (VC0_rd !== 1'b0 || VC1_rd !== 1'b1) begin
        n_err++; $display("FAIL vc1_only[%0d]: got rd0=%b rd1=%b want 0/1", i, VC0_rd, VC1_rd);
      end
      step();
    end
    VC1_empty = 1'b1;
    step();
    n_cmp++;
    if (gnt_cnt1 !== 16'd10 || gnt_cnt0 !== 16'd0) begin
      n_err++; $display("FAIL vc1_only_gnt: got %0d/%0d want 0/10", gnt_cnt0, gnt_cnt1);
    end
  endtask

  task automatic test_data_path();
    do_reset();
    VC0_empty = 1'b0; VC1_empty = 1'b1; pause = 1'b0;
    #1;
    n_cmp++;
    if (VC0_rd !== 1'b1) begin
      n_err++; $display("FAIL data_rd0: got %b want 1", VC0_rd);
    end
    step();
    VC0_empty = 1'b1; VC1_empty = 1'b0;
    VC0_data_out = 6'h2A; VC1_data_out = 6'h15;
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || vc_id !== 1'b0 || data_out !== 6'h2A) begin
      n_err++; $display("FAIL data_vc0: got valid=%b vc_id=%b data=%h want 1/0/2a",
                        valid_out, vc_id, data_out);
    end
    step();
    VC1_empty = 1'b1;
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || vc_id !== 1'b1 || data_out !== 6'h15) begin
      n_err++; $display("FAIL data_vc1: got valid=%b vc_id=%b data=%h want 1/1/15",
                        valid_out, vc_id, data_out);
    end
    step();
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || vc_id !== 1'b1) begin
      n_err++; $display("FAIL data_idle_hold: got valid=%b vc_id=%b want 0/1", valid_out, vc_id);
    end
  endtask

  task automatic test_pause();
    logic [4:0] pat;
    pat = 5'b10000;
    do_reset();
    VC0_empty = 1'b0; VC1_empty = 1'b0; pause = 1'b0;
    for (int i = 0; i < 4; i++) step();  // four VC0 grants: credit now exhausted
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({VC0_rd, VC1_rd} !== 2'b00) begin
        n_err++; $display("FAIL pause_rd[%0d]: got %b want 00", i, {VC0_rd, VC1_rd});
      end
      step();
    end
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL pause_valid: got %b want 0", valid_out);
    end
    pause = 1'b0;
    // from IDLE VC0 wins and gets a fresh run of four
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (VC0_rd !== !pat[i] || VC1_rd !== pat[i]) begin
        n_err++; $display("FAIL pause_resume[%0d]: got rd0=%b rd1=%b want %b/%b",
                          i, VC0_rd, VC1_rd, !pat[i], pat[i]);
      end
      step();
    end
  endtask

  task automatic test_empty_switch();
    do_reset();
    VC0_empty = 1'b0; VC1_empty = 1'b0; pause = 1'b0;
    step(); step();
    VC0_empty = 1'b1;
    #1;
    n_cmp++;
    if (VC0_rd !== 1'b0 || VC1_rd !== 1'b1) begin
      n_err++; $display("FAIL empty_switch: got rd0=%b rd1=%b want 0/1", VC0_rd, VC1_rd);
    end
    step();
    #1;
    n_cmp++;
    if (valid_out !== 1'b1 || vc_id !== 1'b1 || VC1_rd !== 1'b1) begin
      n_err++; $display("FAIL empty_switch_next: got valid=%b vc_id=%b rd1=%b want 1/1/1",
                        valid_out, vc_id, VC1_rd);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    VC0_empty = 1'b0; VC1_empty = 1'b0; pause = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({VC0_rd, VC1_rd} !== 2'b00) begin
      n_err++; $display("FAIL midreset_rd: got %b want 00", {VC0_rd, VC1_rd});
    end
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
      n_err++; $display("FAIL midreset_state: got valid=%b gnt=%0d/%0d want 0 0/0",
                        valid_out, gnt_cnt0, gnt_cnt1);
    end
    n_cmp++;
    if (VC0_rd !== 1'b1 || VC1_rd !== 1'b0) begin
      n_err++; $display("FAIL midreset_restart: got rd0=%b rd1=%b want 1/0", VC0_rd, VC1_rd);
    end
  endtask

  initial begin
    test_reset();
    test_weighted_pattern();
    test_vc1_only();
    test_data_path();
    test_pause();
    test_empty_switch();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
